// File: rtl/utm_pkg.sv
// utm_pkg: state encodings, symbol constants and FSM enum shared by the tape head controller.
package utm_pkg;
    localparam logic [7:0] ST_A = 8'h01, ST_B = 8'h02, ST_C = 8'h04, ST_D = 8'h08;
    localparam logic [7:0] ST_E = 8'h10, ST_F = 8'h20, ST_G = 8'h40, ST_H = 8'h80;
    localparam logic [2:0] SYM_BLANK = 3'b000;
    typedef enum logic [1:0] {IDLE, READ, EXEC, HALT} fsm_t;
    function automatic logic one_hot(input logic [7:0] v);
        return v != 8'h00 && (v & (v - 8'h01)) == 8'h00;
    endfunction
endpackage

// File: rtl/tape_head_ctrl_if.sv
// tape_head_ctrl_if: link between the tape head controller and the external next-state stage.
interface tape_head_ctrl_if;
    logic [7:0] state;
    logic [2:0] sym;
    logic [7:0] state_next;
    logic [2:0] wr_sym;
    logic       mv_left;
    modport master (output state, sym, input state_next, wr_sym, mv_left);
    modport slave (input state, sym, output state_next, wr_sym, mv_left);
endinterface

// File: rtl/tape_ram.sv
// tape_ram: tape storage, one synchronous write port and two asynchronous read ports; never cleared.
module tape_ram #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [2:0]               wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr_a,
    output logic [2:0]               rdata_a,
    input  logic [$clog2(DEPTH)-1:0] raddr_b,
    output logic [2:0]               rdata_b
);
    logic [2:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/tape_head_ctrl.sv
// tape_head_ctrl: Turing-machine tape head sequencer, two cycles per step (READ then EXEC).
// Optional macro UTM_STEP_LIMIT_EN adds a STEP_LIMIT step budget and a sticky timeout output.
module tape_head_ctrl
    import utm_pkg::*;
#(
    parameter int TAPE_DEPTH = 16,
    parameter int STEP_LIMIT = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_valid,
    input  logic [2:0]                    load_sym,
    input  logic                          run,
    tape_head_ctrl_if.master              ns,
    output logic [$clog2(TAPE_DEPTH)-1:0] head,
    output logic                          busy,
    output logic                          halted,
    output logic                          err,
    input  logic [$clog2(TAPE_DEPTH)-1:0] dbg_addr,
    output logic [2:0]                    dbg_sym
`ifdef UTM_STEP_LIMIT_EN
    ,
    output logic                          timeout
`endif
);
    localparam int AW = $clog2(TAPE_DEPTH);
    localparam int CW = $clog2(STEP_LIMIT + 1) + 1;
    fsm_t fsm;
    logic [AW-1:0] load_ptr;
    logic [CW-1:0] step_cnt;
    logic [2:0] head_sym;
    logic ns_ok, we, last;
    assign ns_ok = one_hot(ns.state_next);
    // run beats a coincident load, and reset suppresses any pending write
    assign we = !rst && ((fsm == IDLE && load_valid && !run) || (fsm == EXEC && ns_ok));
`ifdef UTM_STEP_LIMIT_EN
    assign last = step_cnt + CW'(1) == CW'(STEP_LIMIT);
`else
    assign last = 1'b0;
`endif
    tape_ram #(.DEPTH(TAPE_DEPTH)) u_ram (
        .clk     (clk),
        .we      (we),
        .waddr   (fsm == IDLE ? load_ptr : head),
        .wdata   (fsm == IDLE ? load_sym : ns.wr_sym),
        .raddr_a (head),
        .rdata_a (head_sym),
        .raddr_b (dbg_addr),
        .rdata_b (dbg_sym)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm      <= IDLE;
            ns.state <= ST_A;
            ns.sym   <= SYM_BLANK;
            head     <= '0;
            load_ptr <= '0;
            step_cnt <= '0;
            busy     <= 1'b0;
            halted   <= 1'b0;
            err      <= 1'b0;
`ifdef UTM_STEP_LIMIT_EN
            timeout  <= 1'b0;
`endif
        end else begin
            case (fsm)
                IDLE:
                    if (run) begin
                        fsm      <= READ;
                        ns.state <= ST_A;
                        head     <= '0;
                        step_cnt <= '0;
                        load_ptr <= '0;
                        busy     <= 1'b1;
                    end else if (load_valid) begin
                        load_ptr <= load_ptr + AW'(1);
                    end
                READ: begin
                    ns.sym <= head_sym;
                    fsm    <= EXEC;
                end
                EXEC:
                    if (!ns_ok) begin
                        err    <= 1'b1;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        fsm    <= HALT;
                    end else begin
                        ns.state <= ns.state_next;
                        head     <= ns.mv_left ? head - AW'(1) : head + AW'(1);
                        step_cnt <= step_cnt + CW'(1);
                        fsm      <= (ns.state_next == ST_H || last) ? HALT : READ;
                        busy     <= !(ns.state_next == ST_H || last);
                        halted   <= ns.state_next == ST_H || last;
`ifdef UTM_STEP_LIMIT_EN
                        if (last) timeout <= 1'b1;
`endif
                    end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tape_head_ctrl.sv
// tb_tape_head_ctrl: directed scoreboard bench for tape_head_ctrl, bench plays the next-state stage.
// Covers the UTM_STEP_LIMIT_EN timeout check when that macro is defined.
module tb_tape_head_ctrl;
    import utm_pkg::*;
    localparam int D = 16;
    logic clk = 1'b0, rst = 1'b1, load_valid = 1'b0, run = 1'b0;
    logic [2:0] load_sym = 3'd0, dbg_sym, v;
    logic [3:0] head, dbg_addr = 4'd0;
    logic busy, halted, err;
`ifdef UTM_STEP_LIMIT_EN
    logic timeout;
`endif
    tape_head_ctrl_if bus();
    tape_head_ctrl #(.TAPE_DEPTH(D), .STEP_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_sym   (load_sym),
        .run        (run),
        .ns         (bus),
        .head       (head),
        .busy       (busy),
        .halted     (halted),
        .err        (err),
        .dbg_addr   (dbg_addr),
        .dbg_sym    (dbg_sym)
`ifdef UTM_STEP_LIMIT_EN
        ,
        .timeout    (timeout)
`endif
    );
    always #5 clk = ~clk;
    typedef struct {string tag; logic [31:0] v;} exp_t;
    exp_t sb[$];
    int tests = 0, fails = 0, hm = 0;
    logic [2:0] tape_m [D];
    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic expect_v(string tag, logic [31:0] e);
        sb.push_back('{tag, e});
    endtask
    task automatic got(logic [31:0] obs);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL sb_empty observed=%0h expected=none", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
        end
    endtask
    task automatic tape_check(int a);
        expect_v($sformatf("tape%0d", a), 32'(tape_m[a]));
        dbg_addr = 4'(a);
        #1;
        got(32'(dbg_sym));
    endtask
    task automatic status(logic [7:0] st, int hd, logic b, logic h, logic e);
        expect_v("state", 32'(st));
        expect_v("head", 32'(hd));
        expect_v("busy", 32'(b));
        expect_v("halted", 32'(h));
        expect_v("err", 32'(e));
        got(32'(bus.state));
        got(32'(head));
        got(32'(busy));
        got(32'(halted));
        got(32'(err));
    endtask
    task automatic step(logic [7:0] sn, logic [2:0] ws, logic ml);
        int ph = hm;
        bus.state_next = sn;
        bus.wr_sym = ws;
        bus.mv_left = ml;
        expect_v("step_sym", 32'(tape_m[hm]));
        if ($onehot(sn)) begin
            tape_m[hm] = ws;
            hm = ml ? (hm + D - 1) % D : (hm + 1) % D;
        end
        expect_v("step_head", 32'(hm));
        expect_v($sformatf("step_tape%0d", ph), 32'(tape_m[ph]));
        tick();
        got(32'(bus.sym));
        tick();
        got(32'(head));
        dbg_addr = 4'(ph);
        #1;
        got(32'(dbg_sym));
    endtask
    initial begin
        bus.state_next = ST_A;
        bus.wr_sym = SYM_BLANK;
        bus.mv_left = 1'b0;
        tick(2);
        status(ST_A, 0, 1'b0, 1'b0, 1'b0);
        expect_v("rst_sym", 32'(SYM_BLANK));
        got(32'(bus.sym));
        rst = 1'b0;
        for (int i = 0; i < D; i++) begin
            v = (i == 2) ? 3'd2 : (i < 2) ? 3'd1 : 3'(i);
            load_valid = 1'b1;
            load_sym = v;
            tape_m[i] = v;
            tick();
            if (i == 2) begin
                load_valid = 1'b0;
                for (int a = 0; a < 3; a++) tape_check(a);
            end
        end
        tape_check(3);
        tape_check(15);
        load_sym = 3'd7;
        tape_m[0] = 3'd7;
        tick();
        tape_check(0);
        tape_check(1);
        load_sym = 3'b010;
        run = 1'b1;
        tick();
        run = 1'b0;
        load_valid = 1'b0;
        hm = 0;
        tape_check(1);
        status(ST_A, 0, 1'b1, 1'b0, 1'b0);
        step(ST_B, 3'b100, 1'b0);
        status(ST_B, 1, 1'b1, 1'b0, 1'b0);
        step(ST_C, 3'd3, 1'b1);
        step(ST_D, 3'd5, 1'b1);
        status(ST_D, 15, 1'b1, 1'b0, 1'b0);
        step(ST_E, 3'd6, 1'b0);
        step(8'h06, 3'd1, 1'b0);
        status(ST_E, 0, 1'b0, 1'b1, 1'b1);
        run = 1'b1;
        load_valid = 1'b1;
        load_sym = 3'd7;
        tick(3);
        run = 1'b0;
        load_valid = 1'b0;
        status(ST_E, 0, 1'b0, 1'b1, 1'b1);
        tape_check(0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        status(ST_A, 0, 1'b0, 1'b0, 1'b0);
        tape_check(15);
        run = 1'b1;
        tick();
        run = 1'b0;
        hm = 0;
        step(ST_H, 3'd2, 1'b0);
        status(ST_H, 1, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        bus.state_next = ST_B;
        bus.wr_sym = 3'd7;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        status(ST_A, 0, 1'b0, 1'b0, 1'b0);
        tape_check(0);
`ifdef UTM_STEP_LIMIT_EN
        run = 1'b1;
        tick();
        run = 1'b0;
        bus.state_next = ST_B;
        bus.wr_sym = 3'd1;
        bus.mv_left = 1'b0;
        tick(7);
        expect_v("timeout_early", 32'd0);
        got(32'(timeout));
        tick();
        expect_v("timeout", 32'd1);
        expect_v("timeout_halted", 32'd1);
        expect_v("timeout_head", 32'd4);
        got(32'(timeout));
        got(32'(halted));
        got(32'(head));
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tape_head_ctrl.md
TAPE_HEAD_CTRL -- requirements
Module: tape_head_ctrl

Interface
REQ-001 Parameter TAPE_DEPTH, default 16: number of tape cells, power of two.
REQ-002 Parameter STEP_LIMIT, default 1000: step budget when the step-limit feature is compiled in.
REQ-003 Port clk  input  1: single clock; all state changes on rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port load_valid  input  1: write load_sym into the next tape cell (IDLE only).
REQ-006 Port load_sym  input  3: symbol to preload; 3'b000 = blank.
REQ-007 Port run  input  1: start execution from state A, head 0 (IDLE only).
REQ-008 Port state  output  8: registered one-hot current state; drives the next-state stage state_in.
REQ-009 Port sym  output  3: registered symbol under head; drives next-state s2/s1/s0.
REQ-010 Port state_next  input  8: one-hot next state from the next-state stage.
REQ-011 Port wr_sym  input  3: symbol to write at head this step.
REQ-012 Port mv_left  input  1: 1 = head moves left, 0 = head moves right.
REQ-013 Port head  output  $clog2(TAPE_DEPTH): head position.
REQ-014 Port busy  output  1: high in READ/EXEC.
REQ-015 Port halted  output  1: high in HALT.
REQ-016 Port err  output  1: sticky; state_next not one-hot.
REQ-017 Port dbg_addr  input  $clog2(TAPE_DEPTH): tape read address.
REQ-018 Port dbg_sym  output  3: combinational tape[dbg_addr].

Function
REQ-019 FSM states SHALL be IDLE, READ, EXEC, HALT.
REQ-020 IDLE, load_valid=1: tape[load_ptr] <= load_sym and load_ptr increments, wrapping TAPE_DEPTH-1 -> 0.
REQ-021 IDLE, run=1: state <= 8'h01 (A), head <= 0, step_cnt <= 0, load_ptr <= 0, go READ; run wins over a simultaneous load_valid, and that load is dropped.
REQ-022 READ: sym <= tape[head], go EXEC (one cycle).
REQ-023 EXEC: state <= state_next, tape[head] <= wr_sym, head <= head-1 if mv_left else head+1, step_cnt increments, then go READ.
REQ-024 A step SHALL take exactly 2 cycles; state_next is sampled only in EXEC.
REQ-025 Head wrap: left from 0 gives TAPE_DEPTH-1; right from TAPE_DEPTH-1 gives 0.
REQ-026 EXEC with state_next == 8'h80 (H): perform the write and move, latch state = 8'h80, go HALT.
REQ-027 EXEC with state_next not one-hot (zero or multi-hot): no write, no move, state unchanged, err <= 1, go HALT.
REQ-028 HALT SHALL hold all registers until rst.
REQ-029 run and load_valid SHALL be ignored outside IDLE.
REQ-030 dbg_sym SHALL be valid in every state.

Reset
REQ-031 rst SHALL force FSM=IDLE, state=8'h01, sym=0, head=0, load_ptr=0, step_cnt=0, busy=0, halted=0, err=0; it overrides any mid-step activity.
REQ-032 Tape contents SHALL NOT be cleared by rst.

Configuration
REQ-033 Macro UTM_STEP_LIMIT_EN defined: when step_cnt reaches STEP_LIMIT at EXEC, go HALT after that step's write/move, and output timeout (1 bit, sticky, reset 0) is set.
REQ-034 Macro undefined: no timeout port, no limit check; step_cnt remains internal.

Structure
REQ-035 Shared package utm_pkg SHALL hold state encodings (ST_A=8'h01 ... ST_H=8'h80), symbol constants (SYM_BLANK=3'b000), and the FSM state enum.
REQ-036 Tape storage SHALL be sub-module tape_ram: one synchronous write port, two asynchronous read ports (head, dbg).

Verification
REQ-037 Load 1,1,2 (3'b001,3'b001,3'b010) in IDLE -> dbg_addr 0..2 returns 001,001,010; load_ptr=3.
REQ-038 run; bench returns state_next=8'h02, wr_sym=3'b100, mv_left=0 -> after 2 cycles state=8'h02, tape[0]=100, head=1.
REQ-039 From head=0, mv_left=1 -> head=TAPE_DEPTH-1 (15).
REQ-040 state_next=8'h80 -> halted=1 next cycle, busy=0, final write visible on dbg_sym.
REQ-041 state_next=8'h06 -> err=1, halted=1, tape and head unchanged.
REQ-042 rst asserted in EXEC -> next cycle IDLE, state=8'h01, head=0; preloaded tape intact; with UTM_STEP_LIMIT_EN and STEP_LIMIT=4, a looping machine gives timeout=1 after exactly 4 steps (8 cycles after run).
